// File: rtl/saph_vga_timing_ctrl_if.sv
// rtl/saph_vga_timing_ctrl_if.sv - register write/readback port for the VGA timing controller
interface saph_vga_timing_ctrl_if;
  logic        wr_en;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  wr_ready, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/saph_vga_timing_ctrl.sv
// rtl/saph_vga_timing_ctrl.sv - shadowed VGA timing registers with frame-boundary commit and start/stop sequencing
module saph_vga_timing_ctrl #(
  parameter int div_width = 6,
  parameter int x_width   = 10,
  parameter int y_width   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  saph_vga_timing_ctrl_if.slave regs,
  input  logic                 frame_end,
  output logic                 vid_en,
  output logic                 vid_rst,
  output logic [div_width-1:0] vga_clk_div,
  output logic [x_width-1:0]   h_fp_width,
  output logic [x_width-1:0]   h_vid_width,
  output logic [x_width-1:0]   h_bp_width,
  output logic [x_width-1:0]   h_sync_width,
  output logic [y_width-1:0]   v_fp_width,
  output logic [y_width-1:0]   v_vid_width,
  output logic [y_width-1:0]   v_bp_width,
  output logic [y_width-1:0]   v_sync_width,
  output logic                 commit_pending,
  output logic                 running
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_START     = 2'd1,
    ST_RUN       = 2'd2,
    ST_STOP_PEND = 2'd3
  } state_t;

  // 640x480 defaults, index order fp/vid/bp/sync
  localparam logic [x_width-1:0] H_DEF [4] = '{x_width'(15), x_width'(639), x_width'(47), x_width'(95)};
  localparam logic [y_width-1:0] V_DEF [4] = '{y_width'(9), y_width'(479), y_width'(32), y_width'(1)};

  state_t               state, state_nxt;
  logic                 ctrl_en;
  logic                 pending_nxt;
  logic                 do_copy;
  logic                 wr_fire;
  logic                 commit_req;
  logic                 unused_data;
  logic [15:0]          rd_mux;

  logic [div_width-1:0] sh_div;
  logic [x_width-1:0]   sh_h  [4];
  logic [y_width-1:0]   sh_v  [4];
  logic [div_width-1:0] act_div;
  logic [x_width-1:0]   act_h [4];
  logic [y_width-1:0]   act_v [4];

  // Timing registers are locked against writes while a commit is waiting, ctrl never is
  assign regs.wr_ready = !(commit_pending && (regs.wr_addr <= 4'd8));
  assign wr_fire       = regs.wr_en && regs.wr_ready;
  assign commit_req    = wr_fire && (regs.wr_addr == 4'd9) && regs.wr_data[1];
  assign unused_data   = ^regs.wr_data;

  assign running       = (state == ST_RUN) || (state == ST_STOP_PEND);

  assign vga_clk_div   = act_div;
  assign h_fp_width    = act_h[0];
  assign h_vid_width   = act_h[1];
  assign h_bp_width    = act_h[2];
  assign h_sync_width  = act_h[3];
  assign v_fp_width    = act_v[0];
  assign v_vid_width   = act_v[1];
  assign v_bp_width    = act_v[2];
  assign v_sync_width  = act_v[3];

  // Next state, generator controls, and when the shadow set is copied to active
  always_comb begin
    state_nxt   = state;
    pending_nxt = commit_pending;
    do_copy     = 1'b0;
    vid_en      = 1'b0;
    vid_rst     = 1'b1;
    case (state)
      ST_OFF: begin
        if (commit_req) begin
          do_copy     = 1'b1;
          pending_nxt = 1'b0;
        end
        if (ctrl_en) state_nxt = ST_START;
      end
      ST_START: begin
        if (commit_pending) begin
          do_copy     = 1'b1;
          pending_nxt = 1'b0;
        end
        if (commit_req) pending_nxt = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        vid_en  = 1'b1;
        vid_rst = 1'b0;
        if (frame_end && commit_pending) begin
          do_copy     = 1'b1;
          pending_nxt = 1'b0;
        end
        if (commit_req) pending_nxt = 1'b1;
        if (!ctrl_en) state_nxt = ST_STOP_PEND;
      end
      default: begin
        vid_en  = 1'b1;
        vid_rst = 1'b0;
        if (frame_end && commit_pending) begin
          do_copy     = 1'b1;
          pending_nxt = 1'b0;
        end
        if (commit_req) pending_nxt = 1'b1;
        if (ctrl_en)        state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_OFF;
      end
    endcase
  end

  // Sequencer state, commit flag and enable bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_OFF;
      commit_pending <= 1'b0;
      ctrl_en        <= 1'b0;
    end else begin
      state          <= state_nxt;
      commit_pending <= pending_nxt;
      if (wr_fire && (regs.wr_addr == 4'd9)) ctrl_en <= regs.wr_data[0];
    end
  end

  // Shadow registers take accepted writes, truncated to field width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_div <= '0;
      sh_h   <= H_DEF;
      sh_v   <= V_DEF;
    end else if (wr_fire) begin
      if (regs.wr_addr == 4'd0) sh_div <= regs.wr_data[div_width-1:0];
      for (int i = 0; i < 4; i++) begin
        if (regs.wr_addr == 4'(i + 1)) sh_h[i] <= regs.wr_data[x_width-1:0];
        if (regs.wr_addr == 4'(i + 5)) sh_v[i] <= regs.wr_data[y_width-1:0];
      end
    end
  end

  // Active registers change only as a whole set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_div <= '0;
      act_h   <= H_DEF;
      act_v   <= V_DEF;
    end else if (do_copy) begin
      act_div <= sh_div;
      act_h   <= sh_h;
      act_v   <= sh_v;
    end
  end

  // Readback source select
  always_comb begin
    rd_mux = 16'd0;
    case (regs.rd_addr)
      4'd0:    rd_mux = 16'(sh_div);
      4'd1:    rd_mux = 16'(sh_h[0]);
      4'd2:    rd_mux = 16'(sh_h[1]);
      4'd3:    rd_mux = 16'(sh_h[2]);
      4'd4:    rd_mux = 16'(sh_h[3]);
      4'd5:    rd_mux = 16'(sh_v[0]);
      4'd6:    rd_mux = 16'(sh_v[1]);
      4'd7:    rd_mux = 16'(sh_v[2]);
      4'd8:    rd_mux = 16'(sh_v[3]);
      4'd9:    rd_mux = {15'd0, ctrl_en};
      4'd10:   rd_mux = {12'd0, state, commit_pending, running};
      default: rd_mux = 16'd0;
    endcase
  end

  // Registered readback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs.rd_data <= 16'd0;
    else      regs.rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_saph_vga_timing_ctrl.sv
// tb/tb_saph_vga_timing_ctrl.sv - self-checking bench for saph_vga_timing_ctrl
module tb_saph_vga_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_end = 1'b0;
  logic vid_en, vid_rst, commit_pending, running;
  logic [5:0] vga_clk_div;
  logic [9:0] h_fp_width, h_vid_width, h_bp_width, h_sync_width;
  logic [9:0] v_fp_width, v_vid_width, v_bp_width, v_sync_width;

  int errors = 0;
  int checks = 0;

  saph_vga_timing_ctrl_if rif ();

  saph_vga_timing_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .regs           (rif.slave),
    .frame_end      (frame_end),
    .vid_en         (vid_en),
    .vid_rst        (vid_rst),
    .vga_clk_div    (vga_clk_div),
    .h_fp_width     (h_fp_width),
    .h_vid_width    (h_vid_width),
    .h_bp_width     (h_bp_width),
    .h_sync_width   (h_sync_width),
    .v_fp_width     (v_fp_width),
    .v_vid_width    (v_vid_width),
    .v_bp_width     (v_bp_width),
    .v_sync_width   (v_sync_width),
    .commit_pending (commit_pending),
    .running        (running)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Fields 0..8 in register-map order; mode 0=off 1=start 2=run 3=stop-pending
  logic [15:0] m_sh  [9];
  logic [15:0] m_act [9];
  logic        m_en;
  logic        m_pend;
  int          m_mode;
  logic [15:0] m_rd;

  function automatic logic [15:0] reset_val(int i);
    int t [9] = '{0, 15, 639, 47, 95, 9, 479, 32, 1};
    return 16'(t[i]);
  endfunction

  function automatic logic m_ready();
    return !(m_pend && rif.wr_addr <= 4'd8);
  endfunction

  function automatic logic [15:0] m_read(int a);
    if (a <= 8)  return m_sh[a];
    if (a == 9)  return {15'd0, m_en};
    if (a == 10) return 16'(m_mode * 4 + (m_pend ? 2 : 0) + (m_mode >= 2 ? 1 : 0));
    return 16'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_sh[i]  = reset_val(i);
      m_act[i] = reset_val(i);
    end
    m_en = 0; m_pend = 0; m_mode = 0; m_rd = 16'd0;
  endtask

  task automatic model_step();
    int   a;
    logic fire, creq, copy, fe, old_en;
    a      = int'(rif.wr_addr);
    fire   = rif.wr_en && m_ready();
    creq   = fire && a == 9 && rif.wr_data[1];
    fe     = frame_end;
    old_en = m_en;
    copy   = 0;
    m_rd   = m_read(int'(rif.rd_addr));
    if (m_mode == 0) begin
      if (creq) begin copy = 1; m_pend = 0; end
    end else if (m_mode == 1) begin
      if (m_pend) begin copy = 1; m_pend = 0; end
      if (creq) m_pend = 1;
    end else begin
      if (fe && m_pend) begin copy = 1; m_pend = 0; end
      if (creq) m_pend = 1;
    end
    if (copy) for (int i = 0; i < 9; i++) m_act[i] = m_sh[i];
    if (fire && a <= 8) m_sh[a] = (a == 0) ? (rif.wr_data & 16'h003f) : (rif.wr_data & 16'h03ff);
    if (fire && a == 9) m_en = rif.wr_data[0];
    case (m_mode)
      0: if (old_en) m_mode = 1;
      1: m_mode = 2;
      2: if (!old_en) m_mode = 3;
      default: if (old_en) m_mode = 2; else if (fe) m_mode = 0;
    endcase
  endtask

  initial model_reset();
  always @(negedge rst) model_reset();
  always @(posedge clk) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model each cycle, away from the active edge
  always @(negedge clk) begin
    check("vid_en",   32'(vid_en),   32'(m_mode >= 2));
    check("vid_rst",  32'(vid_rst),  32'(m_mode < 2));
    check("running",  32'(running),  32'(m_mode >= 2));
    check("pending",  32'(commit_pending), 32'(m_pend));
    check("wr_ready", 32'(rif.wr_ready), 32'(m_ready()));
    check("rd_data",  32'(rif.rd_data), 32'(m_rd));
    check("div",      32'(vga_clk_div),  32'(m_act[0]));
    check("h_fp",     32'(h_fp_width),   32'(m_act[1]));
    check("h_vid",    32'(h_vid_width),  32'(m_act[2]));
    check("h_bp",     32'(h_bp_width),   32'(m_act[3]));
    check("h_sync",   32'(h_sync_width), 32'(m_act[4]));
    check("v_fp",     32'(v_fp_width),   32'(m_act[5]));
    check("v_vid",    32'(v_vid_width),  32'(m_act[6]));
    check("v_bp",     32'(v_bp_width),   32'(m_act[7]));
    check("v_sync",   32'(v_sync_width), 32'(m_act[8]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(logic [3:0] a, logic [15:0] d);
    rif.wr_en = 1'b1; rif.wr_addr = a; rif.wr_data = d;
    tick();
    rif.wr_en = 1'b0;
  endtask

  task automatic wait_run(string name);
    int k = 0;
    while (!vid_en && k < 10) begin tick(); k++; end
    check(name, 32'(vid_en), 32'd1);
  endtask

  initial begin
    int exp_rd [9] = '{0, 15, 639, 47, 95, 9, 479, 32, 1};
    int k;
    rif.wr_en = 1'b0; rif.wr_addr = 4'd0; rif.wr_data = 16'd0; rif.rd_addr = 4'd0;
    tick(); tick();
    check("rst_vid_en",  32'(vid_en),  32'd0);
    check("rst_vid_rst", 32'(vid_rst), 32'd1);
    check("rst_ready",   32'(rif.wr_ready), 32'd1);
    rst = 1'b1;

    for (int a = 0; a < 9; a++) begin
      rif.rd_addr = 4'(a);
      tick();
      check($sformatf("rst_read%0d", a), 32'(rif.rd_data), 32'(exp_rd[a]));
    end

    // enable latency: write edge, OFF->START, START->RUN
    do_write(4'd9, 16'd1);
    k = 0;
    while (!vid_en && k < 10) begin
      check("start_vid_rst", 32'(vid_rst), 32'd1);
      tick();
      k++;
    end
    check("en_latency", 32'(k + 1), 32'd3);
    check("running_on", 32'(running), 32'd1);

    // commit in RUN waits for frame_end
    do_write(4'd2, 16'd799);
    do_write(4'd9, 16'd3);
    check("hold_h_vid", 32'(h_vid_width), 32'd639);
    check("pend_set",   32'(commit_pending), 32'd1);
    rif.wr_addr = 4'd2;
    #1;
    check("ready_lock", 32'(rif.wr_ready), 32'd0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("commit_h_vid", 32'(h_vid_width), 32'd799);
    check("pend_clr",     32'(commit_pending), 32'd0);
    check("ready_back",   32'(rif.wr_ready), 32'd1);

    // commit write coincident with frame_end applies one frame later
    do_write(4'd2, 16'd640);
    rif.wr_en = 1'b1; rif.wr_addr = 4'd9; rif.wr_data = 16'd3; frame_end = 1'b1;
    tick();
    rif.wr_en = 1'b0; frame_end = 1'b0;
    check("coinc_hold", 32'(h_vid_width), 32'd799);
    check("coinc_pend", 32'(commit_pending), 32'd1);
    tick(); tick();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("coinc_apply", 32'(h_vid_width), 32'd640);

    // stop finishes the frame
    do_write(4'd9, 16'd0);
    tick();
    check("stop_vid_en", 32'(vid_en), 32'd1);
    rif.rd_addr = 4'd10;
    tick();
    check("stop_state", 32'(rif.rd_data[3:2]), 32'd3);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("off_vid_en",  32'(vid_en),  32'd0);
    check("off_vid_rst", 32'(vid_rst), 32'd1);
    tick();
    check("off_state", 32'(rif.rd_data[3:2]), 32'd0);

    // async reset while running with a pending commit
    do_write(4'd9, 16'd1);
    wait_run("rerun");
    do_write(4'd2, 16'd123);
    do_write(4'd9, 16'd3);
    check("pend_before_rst", 32'(commit_pending), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_vid_en",  32'(vid_en), 32'd0);
    check("arst_vid_rst", 32'(vid_rst), 32'd1);
    check("arst_pend",    32'(commit_pending), 32'd0);
    check("arst_h_vid",   32'(h_vid_width), 32'd639);
    tick(); tick();
    rst = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rif.wr_en   = ($urandom_range(0, 2) == 0);
      rif.wr_addr = (r < 30) ? 4'd9 : 4'($urandom_range(0, 15));
      rif.wr_data = 16'($urandom);
      if (rif.wr_addr == 4'd9) begin
        rif.wr_data[0] = ($urandom_range(0, 9) < 8);
        rif.wr_data[1] = ($urandom_range(0, 3) == 0);
      end
      rif.rd_addr = 4'($urandom_range(0, 15));
      frame_end   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end
    rif.wr_en = 1'b0; frame_end = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
